// File: rtl/exp_bias_adder_pipe_pkg.sv
// Shared FP exponent definitions: format widths/biases, all-ones helper, result flag struct.
package fp_exp_pkg;

  localparam int unsigned EXP_W_SP = 8;
  localparam int unsigned BIAS_SP  = 127;
  localparam int unsigned EXP_W_DP = 11;
  localparam int unsigned BIAS_DP  = 1023;

  function automatic logic [31:0] exp_all_ones(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  typedef struct packed {
    logic nan;
    logic special;
    logic zero;
    logic ovf;
    logic udf;
  } exp_flags_t;

endpackage

// File: rtl/exp_bias_adder_pipe_if.sv
// Operand/result stream bundle for exp_bias_adder_pipe; slave is the adder, master the driver.
interface exp_bias_adder_pipe_if #(
  parameter int unsigned EXP_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic             norm_inc;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W-1:0] exp_out;
  logic             ovf;
  logic             udf;
  logic             zero;
  logic             special;
  logic             nan;

  modport master (
    output in_valid, exp_a, exp_b, norm_inc, out_ready,
    input  in_ready, out_valid, exp_out, ovf, udf, zero, special, nan
  );

  modport slave (
    input  in_valid, exp_a, exp_b, norm_inc, out_ready,
    output in_ready, out_valid, exp_out, ovf, udf, zero, special, nan
  );
endinterface

// File: rtl/exp_bias_adder_pipe_classify.sv
// exp_classify: combinational bias removal, class precedence and saturation of the exponent sum.
module exp_classify
  import fp_exp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_SP,
  parameter int unsigned BIAS  = BIAS_SP
) (
  input  logic [EXP_W:0]   raw_i,
  input  logic             za_i,
  input  logic             zb_i,
  input  logic             sa_i,
  input  logic             sb_i,
  output logic [EXP_W-1:0] exp_o,
  output exp_flags_t       flags_o
);

  localparam logic [EXP_W-1:0]        ALL1   = EXP_W'(exp_all_ones(EXP_W));
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);
  // The all-ones code is reserved for inf/NaN, so reaching it already overflows.
  localparam logic signed [EXP_W+1:0] OVF_TH = (EXP_W+2)'(exp_all_ones(EXP_W));

  logic signed [EXP_W+1:0] t;

  always_comb begin
    t       = $signed({1'b0, raw_i}) - BIAS_S;
    flags_o = '0;
    exp_o   = '0;
    if ((za_i && sb_i) || (zb_i && sa_i)) begin
      flags_o.nan     = 1'b1;
      flags_o.special = 1'b1;
      exp_o           = ALL1;
    end else if (sa_i || sb_i) begin
      flags_o.special = 1'b1;
      exp_o           = ALL1;
    end else if (za_i || zb_i) begin
      flags_o.zero = 1'b1;
    end else if (t >= OVF_TH) begin
      flags_o.ovf = 1'b1;
      exp_o       = ALL1;
    end else if (t[EXP_W+1] || (t == '0)) begin
      flags_o.udf = 1'b1;
    end else begin
      exp_o = t[EXP_W-1:0];
    end
  end

endmodule

// File: rtl/exp_bias_adder_pipe.sv
// Two-stage pipelined biased exponent adder with valid/ready backpressure.
// Optional EXP_ADDER_STATS_EN adds saturating overflow/underflow handshake counters.
module exp_bias_adder_pipe
  import fp_exp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_SP,
  parameter int unsigned BIAS  = BIAS_SP
) (
  input  logic clk,
  input  logic rst_n,
  exp_bias_adder_pipe_if.slave bus
`ifdef EXP_ADDER_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] ovf_cnt,
  output logic [15:0] udf_cnt
`endif
);

  localparam logic [EXP_W-1:0] ALL1 = EXP_W'(exp_all_ones(EXP_W));

  logic             s1_valid_q, s1_valid_d;
  logic [EXP_W:0]   raw_q, raw_d;
  logic [3:0]       cls_q, cls_d;   // {za, zb, sa, sb}
  logic             s2_valid_q, s2_valid_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  exp_flags_t       flags_q, flags_d;

  logic             s2_ready;
  logic             in_ready;
  logic             s1_load;
  logic             s2_load;
  logic [EXP_W-1:0] cls_exp;
  exp_flags_t       cls_flags;

  exp_classify #(
    .EXP_W (EXP_W),
    .BIAS  (BIAS)
  ) u_classify (
    .raw_i   (raw_q),
    .za_i    (cls_q[3]),
    .zb_i    (cls_q[2]),
    .sa_i    (cls_q[1]),
    .sb_i    (cls_q[0]),
    .exp_o   (cls_exp),
    .flags_o (cls_flags)
  );

  always_comb begin
    s2_ready   = !s2_valid_q || bus.out_ready;
    in_ready   = !s1_valid_q || s2_ready;
    s1_load    = bus.in_valid && in_ready;
    s2_load    = s2_ready && s1_valid_q;
    s1_valid_d = in_ready ? bus.in_valid : s1_valid_q;
    s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
    raw_d      = raw_q;
    cls_d      = cls_q;
    exp_d      = exp_q;
    flags_d    = flags_q;
    if (s1_load) begin
      raw_d = {1'b0, bus.exp_a} + {1'b0, bus.exp_b} + (EXP_W+1)'(bus.norm_inc);
      cls_d = {bus.exp_a == '0, bus.exp_b == '0, bus.exp_a == ALL1, bus.exp_b == ALL1};
    end
    if (s2_load) begin
      exp_d   = cls_exp;
      flags_d = cls_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      raw_q      <= '0;
      cls_q      <= '0;
      s2_valid_q <= 1'b0;
      exp_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      raw_q      <= raw_d;
      cls_q      <= cls_d;
      s2_valid_q <= s2_valid_d;
      exp_q      <= exp_d;
      flags_q    <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.exp_out   = exp_q;
  assign bus.nan       = flags_q.nan;
  assign bus.special   = flags_q.special;
  assign bus.zero      = flags_q.zero;
  assign bus.ovf       = flags_q.ovf;
  assign bus.udf       = flags_q.udf;

`ifdef EXP_ADDER_STATS_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic [15:0] udf_cnt_q, udf_cnt_d;
  logic        out_fire;

  always_comb begin
    out_fire  = s2_valid_q && bus.out_ready;
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    if (stats_clr) begin
      ovf_cnt_d = '0;
      udf_cnt_d = '0;
    end else begin
      if (out_fire && flags_q.ovf && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + 16'd1;
      if (out_fire && flags_q.udf && (udf_cnt_q != '1)) udf_cnt_d = udf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign udf_cnt = udf_cnt_q;
`endif

endmodule
